// File: rtl/stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_arbiter
// Description : Multi-channel FWFT stream arbiter with priority, round-robin,
//               burst limit and grant hold; one idle cycle per channel switch.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_arbiter #(
    parameter int                N_CH       = 8,
    parameter int                DATA_WIDTH = 32,
    parameter logic [N_CH-1:0]   PRIORITY   = '0,
    parameter int                MAX_BURST  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [N_CH-1:0]              ENABLE,
    input  logic [N_CH-1:0]              WRITE_REQ,
    input  logic [N_CH-1:0]              HOLD_REQ,
    input  logic [N_CH*DATA_WIDTH-1:0]   DATA_IN,
    output logic [N_CH-1:0]              READ_GRANT,
    input  logic                         READY_IN,
    output logic                         WRITE_OUT,
    output logic [DATA_WIDTH-1:0]        DATA_OUT,
    output logic                         GRANT_VALID,
    output logic [$clog2(N_CH)-1:0]      GRANT_CH
);

    localparam int         c_CH_W      = $clog2(N_CH);
    localparam logic [8:0] c_MAX_BURST = 9'(MAX_BURST);
    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_GRANT     = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [c_CH_W-1:0]     r_grant_ch;
    logic [c_CH_W-1:0]     r_last_ch;
    logic [7:0]            r_burst;
    logic                  r_write_out;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic [N_CH-1:0]       w_eligible;
    logic [N_CH-1:0]       w_prio;
    logic                  w_sel_found;
    logic [c_CH_W-1:0]     w_sel_ch;
    int                    w_dist;
    int                    w_best_dist;
    logic                  w_xfer;
    logic                  w_burst_done;
    logic                  w_leave;

    // Channel selection: lowest-index priority channel wins, otherwise the
    // eligible channel at the smallest rotational distance after r_last_ch.
    always_comb begin
        w_eligible  = WRITE_REQ & ENABLE;
        w_prio      = w_eligible & PRIORITY;
        w_sel_found = |w_eligible;
        w_sel_ch    = '0;
        w_dist      = 0;
        w_best_dist = N_CH;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + N_CH - 1 - int'(r_last_ch)) % N_CH;
            if (w_eligible[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_sel_ch    = c_CH_W'(i);
            end
        end
        if (|w_prio) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (w_prio[i]) begin
                    w_sel_ch = c_CH_W'(i);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        w_burst_done = 1'b0;
        w_leave      = 1'b0;
        READ_GRANT   = '0;
        case (r_state)
            c_IDLE: begin
                if (w_sel_found) begin
                    w_state_next = c_GRANT;
                end
            end
            c_GRANT: begin
                w_xfer                 = WRITE_REQ[r_grant_ch] & ENABLE[r_grant_ch] & READY_IN;
                READ_GRANT[r_grant_ch] = w_xfer;
                // 9-bit compare keeps MAX_BURST = 255 exact while saturated
                w_burst_done = w_xfer && (({1'b0, r_burst} + 9'd1) >= c_MAX_BURST);
                w_leave      = !ENABLE[r_grant_ch] ||
                               (!HOLD_REQ[r_grant_ch] && (!WRITE_REQ[r_grant_ch] || w_burst_done));
                if (w_leave) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_grant_ch  <= '0;
            r_last_ch   <= c_CH_W'(N_CH - 1);
            r_burst     <= '0;
            r_write_out <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_write_out <= w_xfer;
            if (w_xfer) begin
                r_data_out <= DATA_IN[r_grant_ch*DATA_WIDTH +: DATA_WIDTH];
            end
            if ((r_state == c_IDLE) && w_sel_found) begin
                r_grant_ch <= w_sel_ch;
                r_burst    <= '0;
            end else if (w_xfer && ({1'b0, r_burst} < c_MAX_BURST)) begin
                r_burst <= r_burst + 8'd1;
            end
            if (w_leave) begin
                r_last_ch <= r_grant_ch;
            end
        end
    end

    assign GRANT_VALID = (r_state == c_GRANT);
    assign GRANT_CH    = r_grant_ch;
    assign WRITE_OUT   = r_write_out;
    assign DATA_OUT    = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_arbiter
// Description : Scoreboard bench for stream_arbiter with modelled FWFT sources.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    en0, wr0, hold0, rg0, en1, wr1, hold1, rg1;
    logic            rdy0, wo0, gv0, rdy1, wo1, gv1;
    logic [N*DW-1:0] din0, din1;
    logic [DW-1:0]   do0, do1;
    logic [1:0]      gc0, gc1;

    int loaded0[N], popped0[N], loaded1[N], popped1[N];
    int exp_seq0[N], exp_seq1[N];
    logic [DW-1:0] exp0[$], exp1[$];
    logic [DW-1:0] m_e0, m_e1;
    logic [N-1:0]  g0, g1;
    int wo_t0[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    stream_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .PRIORITY(4'b0000), .MAX_BURST(4)) u_dut0 (
        .CLK(clk), .RST(rst), .ENABLE(en0), .WRITE_REQ(wr0), .HOLD_REQ(hold0),
        .DATA_IN(din0), .READ_GRANT(rg0), .READY_IN(rdy0), .WRITE_OUT(wo0),
        .DATA_OUT(do0), .GRANT_VALID(gv0), .GRANT_CH(gc0)
    );

    stream_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .PRIORITY(4'b1000), .MAX_BURST(4)) u_dut1 (
        .CLK(clk), .RST(rst), .ENABLE(en1), .WRITE_REQ(wr1), .HOLD_REQ(hold1),
        .DATA_IN(din1), .READ_GRANT(rg1), .READY_IN(rdy1), .WRITE_OUT(wo1),
        .DATA_OUT(do1), .GRANT_VALID(gv1), .GRANT_CH(gc1)
    );

    // FWFT sources: word k of channel i carries {i, k}
    always_comb begin
        wr0  = '0;
        wr1  = '0;
        din0 = '0;
        din1 = '0;
        for (int i = 0; i < N; i++) begin
            wr0[i]         = (loaded0[i] != popped0[i]);
            wr1[i]         = (loaded1[i] != popped1[i]);
            din0[i*DW +: DW] = {4'(i), 12'(popped0[i])};
            din1[i*DW +: DW] = {4'(i), 12'(popped1[i])};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            g0 = rg0;
            g1 = rg1;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                popped0[i] += int'(g0[i]);
                popped1[i] += int'(g1[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (wo0) begin
            n_checks++;
            wo_t0.push_back(cyc);
            if (exp0.size() == 0) begin
                n_fail++;
                $display("FAIL sb0_word: got 0x%0h, expected no word", do0);
            end else begin
                m_e0 = exp0.pop_front();
                if (do0 !== m_e0) begin
                    n_fail++;
                    $display("FAIL sb0_word: got 0x%0h, expected 0x%0h", do0, m_e0);
                end
            end
        end
        if (wo1) begin
            n_checks++;
            if (exp1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_word: got 0x%0h, expected no word", do1);
            end else begin
                m_e1 = exp1.pop_front();
                if (do1 !== m_e1) begin
                    n_fail++;
                    $display("FAIL sb1_word: got 0x%0h, expected 0x%0h", do1, m_e1);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp0(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            exp0.push_back({4'(ch), 12'(exp_seq0[ch])});
            exp_seq0[ch]++;
        end
    endtask

    task automatic push_exp1(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            exp1.push_back({4'(ch), 12'(exp_seq1[ch])});
            exp_seq1[ch]++;
        end
    endtask

    task automatic wait_grant0(input string name, input int ch);
        int ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gv0) begin
                ok = 1;
                break;
            end
        end
        check({name, "_seen"}, ok, 1);
        check({name, "_ch"}, 32'(gc0), ch);
    endtask

    task automatic drain0(input string name);
        for (int c = 0; c < 400 && exp0.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, exp0.size(), 0);
        tick();
    endtask

    int hold_bad;
    int resel_bad;
    int ok1;

    initial begin
        rst = 1'b1;
        en0 = '0; hold0 = '0; rdy0 = 1'b0;
        en1 = '0; hold1 = '0; rdy1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_grant_valid", gv0, 0);
        check("rst_grant_ch", gc0, 0);
        check("rst_write_out", wo0, 0);
        check("rst_data_out", do0, 0);
        check("rst_read_grant", rg0, 0);
        tick();
        rst = 1'b0;

        // Round robin: 4 channels x 10 words, bursts of 4, one gap per switch
        en0 = 4'hF;
        rdy0 = 1'b1;
        wo_t0.delete();
        for (int ch = 0; ch < N; ch++) loaded0[ch] += 10;
        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < N; ch++) push_exp0(ch, 4);
        for (int ch = 0; ch < N; ch++) push_exp0(ch, 2);
        drain0("A_drain");
        check("A_pulses", wo_t0.size(), 40);
        check("A_span_32_words", wo_t0[31] - wo_t0[0], 38);

        // Priority channel 3 wins every IDLE decision until empty
        en1 = 4'hF;
        rdy1 = 1'b1;
        loaded1[0] += 6;
        loaded1[3] += 6;
        push_exp1(3, 6);
        push_exp1(0, 6);
        ok1 = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gv1) begin
                ok1 = 1;
                break;
            end
        end
        check("B_grant_seen", ok1, 1);
        check("B_first_ch", gc1, 3);
        for (int c = 0; c < 400 && exp1.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("B_drain", exp1.size(), 0);
        tick();

        // Hold on channel 1 across gapped traffic while channel 0 waits
        hold0 = 4'b0010;
        loaded0[1] += 4;
        push_exp0(1, 20);
        push_exp0(0, 2);
        wait_grant0("C_grant", 1);
        tick();
        loaded0[0] += 2;
        hold_bad = 0;
        for (int b = 0; b < 5; b++) begin
            if (b > 0) loaded0[1] += 4;
            for (int c = 0; c < 40 && (loaded0[1] - popped0[1]) != 0; c++) begin
                @(negedge clk);
                if (!(gv0 && gc0 == 2'd1)) hold_bad++;
                tick();
            end
            repeat (5) begin
                @(negedge clk);
                if (!(gv0 && gc0 == 2'd1)) hold_bad++;
                tick();
            end
        end
        check("C_hold_kept", hold_bad, 0);
        hold0 = '0;
        drain0("C_drain");

        // READY_IN toggling inside a burst
        rdy0 = 1'b0;
        loaded0[2] += 4;
        push_exp0(2, 4);
        wait_grant0("D_grant", 2);
        for (int k = 0; k < 8; k++) begin
            tick();
            rdy0 = (k % 2 == 0);
            @(negedge clk);
            check($sformatf("D_rg_%0d", k), rg0, (k < 7 && k % 2 == 0) ? 4'b0100 : 4'b0000);
            check($sformatf("D_wo_%0d", k), wo0, (k % 2 == 1));
        end
        tick();
        rdy0 = 1'b1;
        drain0("D_drain");

        // ENABLE[2] dropped mid-burst
        loaded0[2] += 6;
        push_exp0(2, 2);
        push_exp0(3, 2);
        push_exp0(2, 4);
        wait_grant0("E_grant", 2);
        tick();
        tick();
        en0 = 4'b1011;
        loaded0[3] += 2;
        @(negedge clk);
        check("E_rg_off", rg0, 0);
        check("E_still_grant", gv0, 1);
        tick();
        @(negedge clk);
        check("E_idle", gv0, 0);
        resel_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (gv0 && gc0 == 2'd2) resel_bad++;
        end
        check("E_no_reselect", resel_bad, 0);
        tick();
        en0 = 4'hF;
        drain0("E_drain");

        // Async reset during word 2 of a channel-3 burst
        loaded0[3] += 4;
        push_exp0(1, 4);
        exp_seq0[3]++;
        push_exp0(3, 3);
        wait_grant0("F_first", 3);
        tick();
        loaded0[1] += 4;
        #1 rst = 1'b1;
        #1;
        check("F_rst_grant_valid", gv0, 0);
        check("F_rst_grant_ch", gc0, 0);
        check("F_rst_write_out", wo0, 0);
        check("F_rst_data_out", do0, 0);
        check("F_rst_read_grant", rg0, 0);
        tick();
        #1 rst = 1'b0;
        wait_grant0("F_after", 1);
        drain0("F_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
